// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter giving three requesters write access to a single display register.
// Define HEX_DISPLAY_ARBITER_READBACK_EN to add a one-cycle verifying read after each write.
module hex_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [95:0] req_data,
    output logic [2:0]  ack,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic [31:0] cur_value,
    output logic        rd_err
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StHold} state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] cur_value_q, cur_value_d;
    logic [1:0]  pick;
    logic [31:0] pick_data;

`ifdef HEX_DISPLAY_ARBITER_READBACK_EN
    logic rd_err_q, rd_err_d;
`else
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;
`endif

    // Search starts one past the last winner; only meaningful when some req bit is set.
    always_comb begin
        pick = 2'd0;
        case (last_grant_q)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        pick_data = req_data[95:64];
        case (pick)
            2'd0:    pick_data = req_data[31:0];
            2'd1:    pick_data = req_data[63:32];
            default: pick_data = req_data[95:64];
        endcase
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        data_d         = data_q;
        cnt_d          = cnt_q;
        cur_value_d    = cur_value_q;
`ifdef HEX_DISPLAY_ARBITER_READBACK_EN
        rd_err_d       = rd_err_q;
`endif
        ack            = 3'b000;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    last_grant_d = pick;
                    data_d       = pick_data;
                    state_d      = StWrite;
                end
            end
            StWrite: begin
                avm_chipselect    = 1'b1;
                avm_write_n       = 1'b0;
                avm_writedata     = data_q;
                ack[last_grant_q] = 1'b1;
                cur_value_d       = data_q;
`ifdef HEX_DISPLAY_ARBITER_READBACK_EN
                state_d = StRead;
`else
                if (HOLD_CYCLES > 0) begin
                    state_d = StHold;
                    cnt_d   = 8'(HOLD_CYCLES);
                end else begin
                    state_d = StIdle;
                end
`endif
            end
            StRead: begin
`ifdef HEX_DISPLAY_ARBITER_READBACK_EN
                avm_chipselect = 1'b1;
                if (avm_readdata != cur_value_q) rd_err_d = 1'b1;
                if (HOLD_CYCLES > 0) begin
                    state_d = StHold;
                    cnt_d   = 8'(HOLD_CYCLES);
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            StHold: begin
                if (cnt_q <= 8'd1) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 2'd2;
            data_q       <= 32'h0;
            cnt_q        <= 8'd0;
            cur_value_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            cur_value_q  <= cur_value_d;
        end
    end

`ifdef HEX_DISPLAY_ARBITER_READBACK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_err_q <= 1'b0;
        else       rd_err_q <= rd_err_d;
    end
    assign rd_err = rd_err_q;
`else
    assign rd_err = 1'b0;
`endif

    assign avm_address = 2'd0;
    assign busy        = (state_q != StIdle);
    assign cur_value   = cur_value_q;

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, minimum idle cycles after each display write before the next grant (0 to 255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  3  per-requester write request, level, held until ack.
REQ-005 SHALL have port req_data  input  96  requester i value in bits [32*i+31:32*i], stable while req[i]=1.
REQ-006 SHALL have port ack  output  3  one-cycle grant/complete pulse per requester.
REQ-007 SHALL have port avm_address  output  2  display register address, always 0.
REQ-008 SHALL have port avm_chipselect  output  1  display slave select.
REQ-009 SHALL have port avm_write_n  output  1  active-low write strobe.
REQ-010 SHALL have port avm_writedata  output  32  value written to the display register.
REQ-011 SHALL have port avm_readdata  input  32  display register readback (combinational from slave).
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port cur_value  output  32  shadow of the last value written.
REQ-014 SHALL have port rd_err  output  1  sticky readback-mismatch flag.

Function
REQ-015 SHALL implement states IDLE, WRITE, READ, HOLD; HOLD is entered only if HOLD_CYCLES>0.
REQ-016 IDLE: when any req bit is 1, SHALL pick a winner round-robin starting at last_grant+1 (mod 3), latch its req_data, set last_grant, and go to WRITE next cycle.
REQ-017 WRITE (exactly 1 cycle): SHALL drive avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata=latched value, pulse ack[winner]=1, and load cur_value with the latched value.
REQ-018 After WRITE, SHALL go to READ if CONFIG macro is defined, else to HOLD (HOLD_CYCLES>0) or IDLE.
REQ-019 HOLD: SHALL count HOLD_CYCLES cycles with an 8-bit down-counter and then return to IDLE; no grant in HOLD.
REQ-020 Outside WRITE/READ, SHALL drive avm_chipselect=0, avm_write_n=1, avm_writedata=0; ack=0.
REQ-021 Grant-to-bus latency SHALL be 1 cycle (req sampled in IDLE -> write strobe next cycle); back-to-back grant period is 2+HOLD_CYCLES cycles (3+HOLD_CYCLES with readback).
REQ-022 req deasserted before grant SHALL be ignored; req still high in the cycle after its ack SHALL be treated as a new request.
REQ-023 Simultaneous requests: exactly one ack per WRITE; with all three held, grant order SHALL be 0,1,2,0,...
REQ-024 Data changes on req_data after the IDLE latch cycle SHALL NOT affect the write in progress.

Reset
REQ-025 On reset=1, SHALL immediately (asynchronously) enter IDLE, set last_grant=2 (requester 0 first), counter=0, cur_value=0, rd_err=0, ack=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0.
REQ-026 Reset mid-WRITE/READ/HOLD SHALL abort the transfer without ack; first grant after release follows REQ-025 priority.

Configuration
REQ-027 Macro HEX_DISPLAY_ARBITER_READBACK_EN defined: READ state (1 cycle) SHALL drive avm_chipselect=1, avm_write_n=1, avm_address=0, compare avm_readdata with cur_value, and set rd_err=1 on mismatch (sticky until reset).
REQ-028 Macro undefined: no READ state, avm_readdata ignored, rd_err tied 0.

Verification
REQ-029 Single request: req=3'b010, req_data[63:32]=32'h0000_1234 -> write strobe with writedata 32'h0000_1234 next cycle, ack=3'b010 same cycle, cur_value=32'h0000_1234.
REQ-030 Contention: req=3'b111 held, HOLD_CYCLES=4 -> acks in order 001,010,100,001, strobes spaced 6 cycles (7 with readback).
REQ-031 Hold timing: HOLD_CYCLES=0, req=3'b001 held -> write strobe every 2 cycles (3 with readback), busy low one cycle between.
REQ-032 Readback (macro on): slave model returns 32'hDEAD_BEEF after write of 32'h0000_00FF -> rd_err=1 after READ cycle, stays 1 until reset.
REQ-033 Reset mid-HOLD: assert reset during HOLD count 2 -> busy=0, avm_chipselect=0 same cycle; after release req=3'b101 -> ack 001 first.
REQ-034 Data stability: change req_data[31:0] from 32'h1 to 32'h2 in WRITE cycle -> writedata and cur_value remain 32'h1.
